// File: rtl/sram_arbiter_pkg.sv
// Shared constants, width helpers and the read-return slot type for sram_arbiter.
package sram_arbiter_pkg;

    localparam int unsigned RAM_LAT_DEF = 1;
    localparam int unsigned CH_ID_W     = 3;

    function automatic int unsigned be_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Index width that stays at least one bit for a single channel.
    function automatic int unsigned id_w(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    typedef struct packed {
        logic               vld;
        logic [CH_ID_W-1:0] id;
    } ret_slot_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and RAM bus bundle for sram_arbiter; slave modport is the arbiter side.
interface sram_arbiter_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RAM_AW = 14
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [NUM_CH*BE_W-1:0]   ch_cen;
    logic [NUM_CH-1:0]        ch_wr;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_ack;
    logic [NUM_CH-1:0]        ch_rrdy;
    logic [DATA_W-1:0]        ch_rdata;
    logic [BE_W-1:0]          ram_we;
    logic [RAM_AW-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_wdata;
    logic [DATA_W-1:0]        ram_rdata;

    modport master (
        output ch_cen, ch_wr, ch_addr, ch_wdata, ram_rdata,
        input  ch_ack, ch_rrdy, ch_rdata, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  ch_cen, ch_wr, ch_addr, ch_wdata, ram_rdata,
        output ch_ack, ch_rrdy, ch_rdata, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr_i, one-hot grant plus index.
module rr_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]          req_i,
    input  logic [id_w(NUM_CH)-1:0]    ptr_i,
    output logic [NUM_CH-1:0]          gnt_o,
    output logic [id_w(NUM_CH)-1:0]    idx_o,
    output logic                       vld_o
);
    localparam int unsigned IDW = id_w(NUM_CH);

    logic found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        // Offsets 1..NUM_CH from the pointer; offset NUM_CH wraps back to the last winner.
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            for (int j = 0; j < int'(NUM_CH); j++) begin
                if (!found && req_i[j] && (j == ((int'(ptr_i) + k) % int'(NUM_CH)))) begin
                    found = 1'b1;
                    idx_o = IDW'(j);
                end
            end
        end
        for (int j = 0; j < int'(NUM_CH); j++) begin
            gnt_o[j] = found && (idx_o == IDW'(j));
        end
        vld_o = found;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin front end sharing one synchronous RAM among NUM_CH fairy-style requesters.
// Optional per-channel grant/stall counters: define SRAM_ARBITER_PERF_EN.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned RAM_AW  = 14,
    parameter int unsigned RAM_LAT = RAM_LAT_DEF
) (
    input  logic                  aclk,
    input  logic                  areset_n,
`ifdef SRAM_ARBITER_PERF_EN
    output logic [NUM_CH*32-1:0]  perf_grant_cnt,
    output logic [NUM_CH*32-1:0]  perf_stall_cnt,
`endif
    sram_arbiter_if.slave         bus
);
    localparam int unsigned BE_W = be_w(DATA_W);
    localparam int unsigned IDW  = id_w(NUM_CH);

    logic              ready_q;
    logic [IDW-1:0]    rr_ptr_q;
    ret_slot_t         pipe_q [RAM_LAT];

    logic [NUM_CH-1:0] req_c;
    logic [NUM_CH-1:0] gnt_c;
    logic [IDW-1:0]    gnt_idx_c;
    logic              gnt_vld_c;
    logic [BE_W-1:0]   cen_g_c;
    logic              wr_g_c;
    logic [ADDR_W-1:0] addr_g_c;
    logic [DATA_W-1:0] wdata_g_c;
    logic [NUM_CH-1:0] rrdy_c;
    logic              unused_addr_bits;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) ready_q <= 1'b0;
        else           ready_q <= 1'b1;
    end

    always_comb begin
        req_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            req_c[i] = ready_q & (|bus.ch_cen[i*BE_W +: BE_W]);
        end
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req_i (req_c),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_c),
        .idx_o (gnt_idx_c),
        .vld_o (gnt_vld_c)
    );

    // Granted channel's fields to the RAM; everything zero on idle cycles.
    always_comb begin
        cen_g_c   = '0;
        wr_g_c    = 1'b0;
        addr_g_c  = '0;
        wdata_g_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (gnt_c[i]) begin
                cen_g_c   = bus.ch_cen[i*BE_W +: BE_W];
                wr_g_c    = bus.ch_wr[i];
                addr_g_c  = bus.ch_addr[i*ADDR_W +: ADDR_W];
                wdata_g_c = bus.ch_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.ch_ack    = gnt_c;
    assign bus.ram_we    = cen_g_c & {BE_W{wr_g_c}};
    assign bus.ram_addr  = addr_g_c[RAM_AW+1:2];
    assign bus.ram_wdata = wdata_g_c;
    assign unused_addr_bits = ^addr_g_c;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rr_ptr_q <= IDW'(NUM_CH - 1);
        end else if (gnt_vld_c) begin
            rr_ptr_q <= gnt_idx_c;
        end
    end

    // Return pipe tracks which channel owns each in-flight read.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < int'(RAM_LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0].vld <= gnt_vld_c & ~wr_g_c;
            pipe_q[0].id  <= CH_ID_W'(gnt_idx_c);
            for (int i = 1; i < int'(RAM_LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        rrdy_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            rrdy_c[i] = pipe_q[RAM_LAT-1].vld && (pipe_q[RAM_LAT-1].id == CH_ID_W'(i));
        end
    end

    assign bus.ch_rrdy  = rrdy_c;
    assign bus.ch_rdata = bus.ram_rdata;

`ifdef SRAM_ARBITER_PERF_EN
    logic [31:0] grant_cnt_q [NUM_CH];
    logic [31:0] stall_cnt_q [NUM_CH];

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                grant_cnt_q[i] <= '0;
                stall_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (gnt_c[i]) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end else if (|bus.ch_cen[i*BE_W +: BE_W]) begin
                    stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_perf
        assign perf_grant_cnt[g*32 +: 32] = grant_cnt_q[g];
        assign perf_stall_cnt[g*32 +: 32] = stall_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: dut_a is two channels with single-cycle RAM, dut_b is one channel with RAM_LAT=3.
module tb_sram_arbiter;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned RAW = 14;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sram_arbiter_if #(.NUM_CH(2), .DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW)) if_a ();
    sram_arbiter_if #(.NUM_CH(1), .DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW)) if_b ();

    sram_arbiter #(.NUM_CH(2), .DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW), .RAM_LAT(1)) dut_a (
        .aclk(clk), .areset_n(rst_a_n), .bus(if_a));
    sram_arbiter #(.NUM_CH(1), .DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW), .RAM_LAT(3)) dut_b (
        .aclk(clk), .areset_n(rst_b_n), .bus(if_b));

    // Byte-writable synchronous RAM models.
    logic [31:0] mem_a [1<<RAW];
    logic [31:0] mem_b [1<<RAW];
    logic [31:0] rd_a;
    logic [31:0] rd_b [3];

    initial begin
        for (int i = 0; i < (1 << RAW); i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (if_a.ram_we[b]) mem_a[if_a.ram_addr][b*8 +: 8] <= if_a.ram_wdata[b*8 +: 8];
            if (if_b.ram_we[b]) mem_b[if_b.ram_addr][b*8 +: 8] <= if_b.ram_wdata[b*8 +: 8];
        end
        rd_a    <= mem_a[if_a.ram_addr];
        rd_b[0] <= mem_b[if_b.ram_addr];
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end

    assign if_a.ram_rdata = rd_a;
    assign if_b.ram_rdata = rd_b[2];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_a(input int ch, input logic [3:0] cen, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if_a.ch_cen[ch*4 +: 4]    = cen;
        if_a.ch_wr[ch]            = wr;
        if_a.ch_addr[ch*32 +: 32] = addr;
        if_a.ch_wdata[ch*32 +: 32] = wdata;
    endtask

    task automatic idle_a();
        if_a.ch_cen = '0; if_a.ch_wr = '0; if_a.ch_addr = '0; if_a.ch_wdata = '0;
    endtask

    task automatic drive_b(input logic [3:0] cen, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if_b.ch_cen = cen; if_b.ch_wr = wr; if_b.ch_addr = addr; if_b.ch_wdata = wdata;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        idle_a();
        drive_b(4'h0, 1'b0, 32'h0, 32'h0);
        drive_a(0, 4'hF, 1'b0, 32'h0, 32'h0);
        repeat (2) begin
            cyc(); mid();
            total++; if (if_a.ch_ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", if_a.ch_ack); end
            total++; if (if_a.ch_rrdy !== 2'b00) begin bad++; $display("FAIL reset_rrdy got=%b exp=00", if_a.ch_rrdy); end
            total++; if (if_a.ram_we !== 4'h0) begin bad++; $display("FAIL reset_we got=%h exp=0", if_a.ram_we); end
            total++; if (if_a.ram_addr !== 14'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", if_a.ram_addr); end
            total++; if (if_a.ram_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", if_a.ram_wdata); end
        end
        cyc();
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        mid();
        total++; if (if_a.ch_ack !== 2'b00) begin bad++; $display("FAIL release_ack got=%b exp=00", if_a.ch_ack); end
        cyc(); mid();
        total++; if (if_a.ch_ack !== 2'b01) begin bad++; $display("FAIL first_ready_ack got=%b exp=01", if_a.ch_ack); end
        cyc(); idle_a(); mid();
        total++; if (if_a.ch_rrdy !== 2'b01) begin bad++; $display("FAIL first_read_rrdy got=%b exp=01", if_a.ch_rrdy); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  prev = 2'b00;
        logic [1:0]  exp_ack;
        logic [13:0] exp_addr;
        cyc(); rst_a_n = 1'b0;
        cyc(); rst_a_n = 1'b1;
        cyc();
        drive_a(0, 4'hF, 1'b0, 32'h0000_0020, 32'h0);
        drive_a(1, 4'hF, 1'b0, 32'h0000_0040, 32'h0);
        for (int k = 0; k < 6; k++) begin
            mid();
            exp_ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 14'd8 : 14'd16;
            total++; if (if_a.ch_ack !== exp_ack) begin bad++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, if_a.ch_ack, exp_ack); end
            total++; if (if_a.ch_rrdy !== prev) begin bad++; $display("FAIL rr_rrdy[%0d] got=%b exp=%b", k, if_a.ch_rrdy, prev); end
            total++; if (if_a.ram_addr !== exp_addr) begin bad++; $display("FAIL rr_addr[%0d] got=%h exp=%h", k, if_a.ram_addr, exp_addr); end
            prev = exp_ack;
            cyc();
        end
        idle_a(); mid();
        total++; if (if_a.ch_rrdy !== 2'b10) begin bad++; $display("FAIL rr_last_rrdy got=%b exp=10", if_a.ch_rrdy); end
        total++; if (if_a.ch_ack !== 2'b00) begin bad++; $display("FAIL rr_idle_ack got=%b exp=00", if_a.ch_ack); end
    endtask

    task automatic test_write_read();
        cyc();
        drive_a(0, 4'hF, 1'b1, 32'h0000_0010, 32'hDEADBEEF); mid();
        total++; if (if_a.ch_ack !== 2'b01) begin bad++; $display("FAIL wr_ack got=%b exp=01", if_a.ch_ack); end
        total++; if (if_a.ram_we !== 4'hF) begin bad++; $display("FAIL wr_we got=%h exp=f", if_a.ram_we); end
        total++; if (if_a.ram_addr !== 14'd4) begin bad++; $display("FAIL wr_addr got=%h exp=4", if_a.ram_addr); end
        total++; if (if_a.ram_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata got=%h exp=deadbeef", if_a.ram_wdata); end
        cyc();
        drive_a(0, 4'hF, 1'b0, 32'h0000_0010, 32'h0); mid();
        total++; if (if_a.ch_ack !== 2'b01) begin bad++; $display("FAIL rd_ack got=%b exp=01", if_a.ch_ack); end
        total++; if (if_a.ch_rrdy !== 2'b00) begin bad++; $display("FAIL write_no_rrdy got=%b exp=00", if_a.ch_rrdy); end
        total++; if (if_a.ram_we !== 4'h0) begin bad++; $display("FAIL rd_we got=%h exp=0", if_a.ram_we); end
        cyc(); idle_a(); mid();
        total++; if (if_a.ch_rrdy !== 2'b01) begin bad++; $display("FAIL rd_rrdy got=%b exp=01", if_a.ch_rrdy); end
        total++; if (if_a.ch_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", if_a.ch_rdata); end
    endtask

    task automatic test_byte_enable();
        cyc(); drive_a(0, 4'hF, 1'b1, 32'h0000_0014, 32'h11223344);
        cyc(); drive_a(0, 4'b0010, 1'b1, 32'h0000_0014, 32'h0000AA00); mid();
        total++; if (if_a.ram_we !== 4'b0010) begin bad++; $display("FAIL be_we got=%b exp=0010", if_a.ram_we); end
        cyc(); drive_a(0, 4'hF, 1'b0, 32'h0000_0014, 32'h0);
        cyc(); idle_a(); mid();
        total++; if (if_a.ch_rrdy !== 2'b01) begin bad++; $display("FAIL be_rrdy got=%b exp=01", if_a.ch_rrdy); end
        total++; if (if_a.ch_rdata !== 32'h1122AA44) begin bad++; $display("FAIL be_data got=%h exp=1122aa44", if_a.ch_rdata); end
    endtask

    task automatic test_alias();
        cyc(); drive_a(0, 4'hF, 1'b1, 32'h0001_0018, 32'hCAFEF00D); mid();
        total++; if (if_a.ram_addr !== 14'd6) begin bad++; $display("FAIL alias_addr got=%h exp=6", if_a.ram_addr); end
        cyc(); drive_a(0, 4'hF, 1'b0, 32'h0000_0018, 32'h0);
        cyc(); idle_a(); mid();
        total++; if (if_a.ch_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL alias_data got=%h exp=cafef00d", if_a.ch_rdata); end
    endtask

    task automatic test_stall();
        cyc();
        drive_a(0, 4'hF, 1'b1, 32'h0000_0030, 32'hAAAA0000);
        drive_a(1, 4'hF, 1'b1, 32'h0000_0034, 32'hBBBB1111);
        mid();
        total++; if (if_a.ch_ack !== 2'b10) begin bad++; $display("FAIL stall_ack0 got=%b exp=10", if_a.ch_ack); end
        total++; if (if_a.ram_wdata !== 32'hBBBB1111) begin bad++; $display("FAIL stall_wdata0 got=%h exp=bbbb1111", if_a.ram_wdata); end
        cyc(); drive_a(1, 4'h0, 1'b0, 32'h0, 32'h0); mid();
        total++; if (if_a.ch_ack !== 2'b01) begin bad++; $display("FAIL stall_ack1 got=%b exp=01", if_a.ch_ack); end
        total++; if (if_a.ram_addr !== 14'd12) begin bad++; $display("FAIL stall_addr1 got=%h exp=c", if_a.ram_addr); end
        total++; if (if_a.ram_wdata !== 32'hAAAA0000) begin bad++; $display("FAIL stall_wdata1 got=%h exp=aaaa0000", if_a.ram_wdata); end
        cyc(); idle_a();
    endtask

    task automatic test_latency_sweep();
        logic exp_rrdy;
        for (int i = 0; i < 4; i++) begin
            cyc(); drive_b(4'hF, 1'b1, 32'(4 * i), 32'(i + 1)); mid();
            total++; if (if_b.ch_ack !== 1'b1) begin bad++; $display("FAIL sweep_wr_ack[%0d] got=%b exp=1", i, if_b.ch_ack); end
        end
        for (int k = 0; k < 7; k++) begin
            cyc();
            if (k < 4) drive_b(4'hF, 1'b0, 32'(4 * k), 32'h0);
            else       drive_b(4'h0, 1'b0, 32'h0, 32'h0);
            mid();
            exp_rrdy = (k >= 3);
            total++; if (if_b.ch_ack !== 1'(k < 4)) begin bad++; $display("FAIL sweep_ack[%0d] got=%b exp=%b", k, if_b.ch_ack, (k < 4)); end
            total++; if (if_b.ch_rrdy !== exp_rrdy) begin bad++; $display("FAIL sweep_rrdy[%0d] got=%b exp=%b", k, if_b.ch_rrdy, exp_rrdy); end
            if (exp_rrdy) begin
                total++; if (if_b.ch_rdata !== 32'(k - 2)) begin bad++; $display("FAIL sweep_data[%0d] got=%h exp=%h", k, if_b.ch_rdata, k - 2); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        cyc(); drive_b(4'hF, 1'b0, 32'h0000_0008, 32'h0); mid();
        total++; if (if_b.ch_ack !== 1'b1) begin bad++; $display("FAIL mid_rd_ack got=%b exp=1", if_b.ch_ack); end
        cyc(); drive_b(4'h0, 1'b0, 32'h0, 32'h0); rst_b_n = 1'b0; mid();
        total++; if (if_b.ch_rrdy !== 1'b0) begin bad++; $display("FAIL mid_rst_rrdy got=%b exp=0", if_b.ch_rrdy); end
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k == 1) rst_b_n = 1'b1;
            mid();
            total++; if (if_b.ch_rrdy !== 1'b0) begin bad++; $display("FAIL mid_rst_rrdy[%0d] got=%b exp=0", k, if_b.ch_rrdy); end
        end
        cyc(); drive_b(4'hF, 1'b0, 32'h0000_0008, 32'h0); mid();
        total++; if (if_b.ch_ack !== 1'b1) begin bad++; $display("FAIL recover_ack got=%b exp=1", if_b.ch_ack); end
        cyc(); drive_b(4'h0, 1'b0, 32'h0, 32'h0);
        cyc(); cyc(); mid();
        total++; if (if_b.ch_rrdy !== 1'b1) begin bad++; $display("FAIL recover_rrdy got=%b exp=1", if_b.ch_rrdy); end
        total++; if (if_b.ch_rdata !== 32'd3) begin bad++; $display("FAIL recover_data got=%h exp=3", if_b.ch_rdata); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_byte_enable();
        test_alias();
        test_stall();
        test_latency_sweep();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
